// File: rtl/uart_tx_serializer_if.sv
// Byte-write handshake between a producer and the UART transmit serializer.
// The producer drives tx_wr/tx_data; the serializer returns tbr (holding register empty).
interface uart_tx_serializer_if;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tbr;

    modport master (output tx_wr, output tx_data, input tbr);
    modport slave  (input tx_wr, input tx_data, output tbr);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-entry holding register feeding an LSB-first 8N1 shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16,
    parameter int TCW        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    uart_tx_serializer_if.slave  bus,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] TICK_ONE  = TCW'(1);

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    state_t         state_r, state_n;
    logic [TCW-1:0] tick_cnt_r, tick_cnt_n;
    logic [2:0]     bit_idx_r, bit_idx_n;
    logic [7:0]     shift_r, shift_n;
    logic [7:0]     hold_r, hold_n;
    logic           hold_full_r, hold_full_n;
    logic           txd_r, txd_n;
    logic           tx_done_r, tx_done_n;
    logic           busy_r;
    logic           tbr_r;
    logic           tick_s, adv_s, load_s, wr_acc_s;
`ifdef UART_TX_PARITY_EN
    logic           parity_r, parity_n;
`endif

    // Next-state, bit timing, holding-register and line-level logic.
    always_comb begin
        state_n     = state_r;
        tick_cnt_n  = tick_cnt_r;
        bit_idx_n   = bit_idx_r;
        shift_n     = shift_r;
        hold_n      = hold_r;
        hold_full_n = hold_full_r;
        txd_n       = txd_r;
        tx_done_n   = 1'b0;
        load_s      = 1'b0;
        adv_s       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n    = parity_r;
`endif
        wr_acc_s = bus.tx_wr && tbr_r;
        tick_s   = baud_tick && (state_r != IDLE);

        if (tick_s) begin
            if (tick_cnt_r == TICK_LAST) begin
                tick_cnt_n = '0;
                adv_s      = 1'b1;
            end else begin
                tick_cnt_n = tick_cnt_r + TICK_ONE;
            end
        end else begin
            tick_cnt_n = tick_cnt_r;
        end

        case (state_r)
            IDLE: begin
                txd_n  = 1'b1;
                load_s = hold_full_r;
            end
            START: begin
                if (adv_s) begin
                    state_n = DATA;
                    txd_n   = shift_r[0];
                end else begin
                    txd_n   = 1'b0;
                end
            end
            DATA: begin
                if (adv_s) begin
                    shift_n   = {1'b0, shift_r[7:1]};
                    bit_idx_n = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = parity_r;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        txd_n   = shift_r[1];
                    end
                end else begin
                    txd_n = shift_r[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (adv_s) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end else begin
                    txd_n   = parity_r;
                end
            end
`endif
            STOP: begin
                txd_n = 1'b1;
                if (adv_s) begin
                    tx_done_n = 1'b1;
                    // A waiting byte starts its start bit on this same edge: no idle bit.
                    if (hold_full_r) begin
                        load_s  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    tx_done_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase

        if (load_s) begin
            shift_n     = hold_r;
            hold_full_n = 1'b0;
            tick_cnt_n  = '0;
            bit_idx_n   = 3'd0;
            state_n     = START;
            txd_n       = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_n    = even_parity(hold_r);
`endif
        end else if (wr_acc_s) begin
            hold_n      = bus.tx_data;
            hold_full_n = 1'b1;
        end else begin
            hold_n      = hold_r;
        end
    end

    // State and output registers; reset discards any frame and held byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            tick_cnt_r  <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            txd_r       <= 1'b1;
            tx_done_r   <= 1'b0;
            busy_r      <= 1'b0;
            tbr_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            tick_cnt_r  <= tick_cnt_n;
            bit_idx_r   <= bit_idx_n;
            shift_r     <= shift_n;
            hold_r      <= hold_n;
            hold_full_r <= hold_full_n;
            txd_r       <= txd_n;
            tx_done_r   <= tx_done_n;
            busy_r      <= (state_n != IDLE);
            tbr_r       <= ~hold_full_n;
`ifdef UART_TX_PARITY_EN
            parity_r    <= parity_n;
`endif
        end
    end

    assign txd     = txd_r;
    assign busy    = busy_r;
    assign tx_done = tx_done_r;
    assign bus.tbr = tbr_r;

`ifndef UART_TX_PARITY_EN
    // Parity helper only feeds the parity register in the 8E1 build.
    logic unused_parity_s;
    assign unused_parity_s = even_parity(hold_r);
`endif

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage. Sits directly downstream of the baud-rate down-counter and consumes its `zero` output as `baud_tick`.
- Accepts bytes from the bus interface into a one-entry holding register, then serializes them LSB-first on `txd` as 8N1 frames.
- Every bit lasts OVERSAMPLE baud ticks.
- Double buffering allows back-to-back frames with no idle gap.

Parameters:
- OVERSAMPLE, 16, baud ticks per serial bit (legal range 1..256)
- TCW, 8, tick counter width; must satisfy 2^TCW >= OVERSAMPLE

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- baud_tick  input  1  one baud tick per cycle it is high; may be high on consecutive cycles
- tx_wr  input  1  write strobe for tx_data
- tx_data  input  8  byte to transmit
- txd  output  1  serial line, idles high
- tbr  output  1  transmit buffer ready: holding register empty
- busy  output  1  frame in progress (state != IDLE)
- tx_done  output  1  one-cycle pulse when a stop bit completes

Behaviour:
- Reset: reset is clk with rst, synchronous, active-high. Reset values: txd=1, tbr=1, busy=0, tx_done=0, state=IDLE, tick_cnt=0, hold_full=0, shift=0. Reset mid-frame aborts the frame immediately: txd returns high on the next edge and the held byte is discarded.
- Write path:
  - tx_wr with tbr=1 loads hold<=tx_data and hold_full<=1; tbr falls next cycle.
  - tx_wr with tbr=0 is ignored; the held byte is not overwritten.
- State machine: IDLE, START, DATA, STOP.
- IDLE: txd=1. If hold_full=1, on the next edge:
  - shift<=hold, hold_full<=0, tick_cnt<=0, bit_idx<=0, state<=START, txd<=0.
  - Latency from a tx_wr accepted in IDLE to txd low is 2 cycles.
- Bit timing (applies in START, DATA, STOP):
  - Only cycles with baud_tick=1 count.
  - On a tick: if tick_cnt==OVERSAMPLE-1, then tick_cnt<=0 and the bit advances; otherwise tick_cnt increments.
  - No tick means no change.
- START: txd=0. On advance: state<=DATA, txd<=shift[0].
- DATA: txd=shift[0]. On advance:
  - shift>>=1, bit_idx++.
  - If bit_idx was 7, state<=STOP and txd<=1.
  - Otherwise txd<=next bit.
- STOP: txd=1. On advance, tx_done=1 for one cycle, then:
  - If hold_full=1: load as in IDLE and go directly to START on the same edge, so there is no idle bit.
  - Otherwise: state<=IDLE.
- Buffer release: tbr rises the cycle after the holding register transfers to the shift register, which permits a new write during the current frame.
- Simultaneous events:
  - tx_wr in the same cycle the holding register transfers is ignored, because tbr is still 0.
  - baud_tick while in IDLE is ignored.
  - tx_wr in the STOP-advance cycle with hold empty is accepted; the frame starts from IDLE two cycles later.
- Frame length: exactly 10*OVERSAMPLE ticks, measured from the first tick after txd falls, plus one cycle for the load edge.
- tick_cnt: never exceeds OVERSAMPLE-1; wraps to 0.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP.
  - txd carries even parity, the XOR of the 8 data bits, computed at load time.
  - Frame is 11 bits (8E1), 11*OVERSAMPLE ticks.
  - DATA bit 7 advances to PARITY; PARITY advances to STOP.
- Undefined: no PARITY state, no parity register, 8N1 frames.

Test Plan:
- Reset with rst=1 for 2 cycles while toggling tx_wr and baud_tick -> txd=1, tbr=1, busy=0, tx_done=0 throughout and after release.
- OVERSAMPLE=16, baud_tick every 4th cycle, write 0xA5 -> txd samples at bit centres read 0, 1,0,1,0,0,1,0,1, 1; tx_done pulses once; busy spans 160 ticks (+/-1 tick).
- Write 0x3C, then write 0xC3 while 0x3C is in DATA (tbr=1) -> the second frame's start bit begins at the edge the first stop bit ends, with no idle gap; 2 tx_done pulses.
- With tbr=0, write 0x11 then 0x22 -> only 0x11 is transmitted, and 0x22 is dropped.
- Assert rst mid-DATA of 0xFF with a byte held -> txd=1 next cycle, busy=0, tbr=1; no frame follows after rst release.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 11 bits; send 0x03 -> parity bit 0.
